// File: rtl/jogo_fluxo_dados_param_if.sv
// Control/status bundle between the game control unit and the parametrised datapath.
interface jogo_fluxo_dados_param_if #(
    parameter int unsigned N_BOTOES = 4,
    parameter int unsigned ADDR_W   = 4
) ();

    logic [N_BOTOES-1:0] botoes;
    logic                nivel_jogadas;
    logic                nivel_tempo;
    logic                modo_escrita;
    logic                registraN;
    logic                zeraC;
    logic                contaC;
    logic                zeraCR;
    logic                contaCR;
    logic                registraR;
    logic                escreveM;
    logic                zeraTM;
    logic                contaTM;
    logic                zeraTempo;
    logic                contaTempo;
    logic                ativa_leds;

    logic                jogada_feita;
    logic                jogada_valida;
    logic                jogada_correta;
    logic                nivel_jogadas_reg;
    logic                nivel_tempo_reg;
    logic                modo_escrita_reg;
    logic                fimC;
    logic                enderecoIgualRodada;
    logic                fimCR;
    logic                fimTM;
    logic                meioTM;
    logic                fimTempo;
    logic                meioTempo;
    logic [N_BOTOES-1:0] leds;
    logic [ADDR_W-1:0]   db_endereco;
    logic [ADDR_W-1:0]   db_rodada;
    logic [N_BOTOES-1:0] db_jogada;
    logic [N_BOTOES-1:0] db_memoria;

    // Control unit / board side
    modport master (
        output botoes, nivel_jogadas, nivel_tempo, modo_escrita, registraN,
               zeraC, contaC, zeraCR, contaCR, registraR, escreveM,
               zeraTM, contaTM, zeraTempo, contaTempo, ativa_leds,
        input  jogada_feita, jogada_valida, jogada_correta,
               nivel_jogadas_reg, nivel_tempo_reg, modo_escrita_reg,
               fimC, enderecoIgualRodada, fimCR, fimTM, meioTM,
               fimTempo, meioTempo, leds, db_endereco, db_rodada,
               db_jogada, db_memoria
    );

    // Datapath side
    modport slave (
        input  botoes, nivel_jogadas, nivel_tempo, modo_escrita, registraN,
               zeraC, contaC, zeraCR, contaCR, registraR, escreveM,
               zeraTM, contaTM, zeraTempo, contaTempo, ativa_leds,
        output jogada_feita, jogada_valida, jogada_correta,
               nivel_jogadas_reg, nivel_tempo_reg, modo_escrita_reg,
               fimC, enderecoIgualRodada, fimCR, fimTM, meioTM,
               fimTempo, meioTempo, leds, db_endereco, db_rodada,
               db_jogada, db_memoria
    );

endinterface

// File: rtl/jogo_fluxo_dados_param.sv
// Parametrised datapath of the memory-sequence game: writable sequence memory,
// address/round counters, display and timeout timers, play capture and compare.
module jogo_fluxo_dados_param #(
    parameter int unsigned N_BOTOES         = 4,
    parameter int unsigned PROFUNDIDADE     = 16,
    parameter int unsigned ADDR_W           = 4,
    parameter int unsigned T_MOSTRA         = 5000,
    parameter int unsigned T_TIMEOUT        = 15000,
    parameter int unsigned T_TIMEOUT_RAPIDO = 7500
) (
    input logic                    clock,
    input logic                    reset,
    jogo_fluxo_dados_param_if.slave bus
);

    localparam int unsigned TM_W   = $clog2(T_MOSTRA);
    localparam int unsigned TO_MAX = (T_TIMEOUT > T_TIMEOUT_RAPIDO) ? T_TIMEOUT : T_TIMEOUT_RAPIDO;
    localparam int unsigned TO_W   = $clog2(TO_MAX);

    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(PROFUNDIDADE - 1);
    localparam logic [ADDR_W-1:0] ROUND_HALF = ADDR_W'(PROFUNDIDADE / 2 - 1);
    localparam logic [TM_W-1:0]   TM_LAST    = TM_W'(T_MOSTRA - 1);
    localparam logic [TM_W-1:0]   TM_HALF    = TM_W'(T_MOSTRA / 2 - 1);

    logic [ADDR_W-1:0]   endereco_q, endereco_d;
    logic [ADDR_W-1:0]   rodada_q,   rodada_d;
    logic [TM_W-1:0]     tm_q,       tm_d;
    logic [TO_W-1:0]     to_q,       to_d;
    logic [N_BOTOES-1:0] jogada_q,   jogada_d;
    logic                nj_q,       nj_d;
    logic                nt_q,       nt_d;
    logic                me_q,       me_d;
    logic                prev_q,     prev_d;

    logic [N_BOTOES-1:0] mem_q [PROFUNDIDADE];
    logic [N_BOTOES-1:0] rdata_q;

    logic                botao_c;
    logic                jogada_feita_c;
    logic                escreve_c;
    logic [TO_W-1:0]     to_last_c;
    logic [TO_W-1:0]     to_half_c;
    logic [ADDR_W-1:0]   rodada_lim_c;
    logic                onehot_c;

    assign botao_c        = |bus.botoes;
    assign jogada_feita_c = botao_c & ~prev_q;
    assign escreve_c      = bus.escreveM & me_q & ~reset;

    // Timeout modulus follows the latched speed level
    assign to_last_c = nt_q ? TO_W'(T_TIMEOUT_RAPIDO - 1)     : TO_W'(T_TIMEOUT - 1);
    assign to_half_c = nt_q ? TO_W'(T_TIMEOUT_RAPIDO / 2 - 1) : TO_W'(T_TIMEOUT / 2 - 1);

    assign rodada_lim_c = nj_q ? ADDR_LAST : ROUND_HALF;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing
    assign onehot_c = (jogada_q != '0) && ((jogada_q & (jogada_q - N_BOTOES'(1))) == '0);

    // Next-state for every register
    always_comb begin
        endereco_d = endereco_q;
        rodada_d   = rodada_q;
        tm_d       = tm_q;
        to_d       = to_q;
        jogada_d   = jogada_q;
        nj_d       = nj_q;
        nt_d       = nt_q;
        me_d       = me_q;
        prev_d     = botao_c;

        if (bus.registraN) begin
            nj_d = bus.nivel_jogadas;
            nt_d = bus.nivel_tempo;
            me_d = bus.modo_escrita;
        end

        if (bus.registraR) begin
            jogada_d = bus.botoes;
        end

        if (bus.zeraC) begin
            endereco_d = '0;
        end else if (bus.contaC) begin
            endereco_d = (endereco_q == ADDR_LAST) ? '0 : endereco_q + ADDR_W'(1);
        end

        if (bus.zeraCR) begin
            rodada_d = '0;
        end else if (bus.contaCR && (rodada_q != ADDR_LAST)) begin
            rodada_d = rodada_q + ADDR_W'(1);
        end

        if (bus.zeraTM) begin
            tm_d = '0;
        end else if (bus.contaTM) begin
            tm_d = (tm_q >= TM_LAST) ? '0 : tm_q + TM_W'(1);
        end

        // A fresh play restarts the timeout window
        if (bus.zeraTempo || jogada_feita_c) begin
            to_d = '0;
        end else if (bus.contaTempo) begin
            to_d = (to_q >= to_last_c) ? '0 : to_q + TO_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            endereco_q <= '0;
            rodada_q   <= '0;
            tm_q       <= '0;
            to_q       <= '0;
            jogada_q   <= '0;
            nj_q       <= 1'b0;
            nt_q       <= 1'b0;
            me_q       <= 1'b0;
            prev_q     <= 1'b1;
        end else begin
            endereco_q <= endereco_d;
            rodada_q   <= rodada_d;
            tm_q       <= tm_d;
            to_q       <= to_d;
            jogada_q   <= jogada_d;
            nj_q       <= nj_d;
            nt_q       <= nt_d;
            me_q       <= me_d;
            prev_q     <= prev_d;
        end
    end

    // Sequence memory: unreset storage, registered read with write-through
    always_ff @(posedge clock) begin
        if (escreve_c) begin
            mem_q[endereco_q] <= jogada_q;
        end
        rdata_q <= escreve_c ? jogada_q : mem_q[endereco_q];
    end

    assign bus.jogada_feita        = jogada_feita_c;
    assign bus.jogada_valida       = onehot_c;
    assign bus.jogada_correta      = onehot_c && (jogada_q == rdata_q);
    assign bus.nivel_jogadas_reg   = nj_q;
    assign bus.nivel_tempo_reg     = nt_q;
    assign bus.modo_escrita_reg    = me_q;
    assign bus.fimC                = (endereco_q == ADDR_LAST);
    assign bus.enderecoIgualRodada = (endereco_q == rodada_q);
    assign bus.fimCR               = (rodada_q == rodada_lim_c);
    assign bus.fimTM               = (tm_q == TM_LAST);
    assign bus.meioTM              = (tm_q == TM_HALF);
    assign bus.fimTempo            = (to_q == to_last_c);
    assign bus.meioTempo           = (to_q == to_half_c);
    assign bus.leds                = bus.ativa_leds ? rdata_q : '0;
    assign bus.db_endereco         = endereco_q;
    assign bus.db_rodada           = rodada_q;
    assign bus.db_jogada           = jogada_q;
    assign bus.db_memoria          = rdata_q;

endmodule

// File: tb/tb_jogo_fluxo_dados_param.sv
// Scoreboard bench: driver pushes model predictions per cycle, negedge monitor compares.
module tb_jogo_fluxo_dados_param;

    localparam int unsigned NB   = 4;
    localparam int unsigned PROF = 16;
    localparam int unsigned AW   = 4;
    localparam int unsigned TMS  = 5000;
    localparam int unsigned TOS  = 15000;
    localparam int unsigned TOR  = 7500;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    jogo_fluxo_dados_param_if #(.N_BOTOES(NB), .ADDR_W(AW)) bus ();

    jogo_fluxo_dados_param #(
        .N_BOTOES(NB), .PROFUNDIDADE(PROF), .ADDR_W(AW),
        .T_MOSTRA(TMS), .T_TIMEOUT(TOS), .T_TIMEOUT_RAPIDO(TOR)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct packed {
        logic          reset;
        logic [NB-1:0] botoes;
        logic nj, nt, me, registraN;
        logic zeraC, contaC, zeraCR, contaCR, registraR, escreveM;
        logic zeraTM, contaTM, zeraTempo, contaTempo, ativa;
    } drv_t;

    typedef struct {
        bit jf, jv, jc, jc_known;
        bit nj, nt, me;
        bit fimC, eir, fimCR, fimTM, meioTM, fimTo, meioTo;
        int leds; bit leds_known;
        int endr, rod, jog, memw; bit mem_known;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    bit   m_valid = 0;
    int   m_addr, m_round, m_tm, m_to, m_play, m_rd;
    bit   m_nj, m_nt, m_me, m_prev, m_rd_known;
    int   m_mem   [PROF];
    bit   m_known [PROF];

    initial for (int i = 0; i < PROF; i++) m_known[i] = 0;

    function automatic exp_t predict(input drv_t d);
        exp_t e;
        int   to_m;
        to_m         = m_nt ? TOR : TOS;
        e.jf         = (d.botoes != 0) && !m_prev;
        e.jv         = ($countones(4'(m_play)) == 1);
        e.jc         = e.jv && (m_play == m_rd);
        e.jc_known   = !e.jv || m_rd_known;
        e.nj         = m_nj;
        e.nt         = m_nt;
        e.me         = m_me;
        e.fimC       = (m_addr == PROF - 1);
        e.eir        = (m_addr == m_round);
        e.fimCR      = (m_round == (m_nj ? PROF - 1 : PROF / 2 - 1));
        e.fimTM      = (m_tm == TMS - 1);
        e.meioTM     = (m_tm == TMS / 2 - 1);
        e.fimTo      = (m_to == to_m - 1);
        e.meioTo     = (m_to == to_m / 2 - 1);
        e.leds       = d.ativa ? m_rd : 0;
        e.leds_known = !d.ativa || m_rd_known;
        e.endr       = m_addr;
        e.rod        = m_round;
        e.jog        = m_play;
        e.memw       = m_rd;
        e.mem_known  = m_rd_known;
        return e;
    endfunction

    task automatic model_step(input drv_t d);
        bit jf;
        int to_m;
        jf   = (d.botoes != 0) && !m_prev;
        to_m = m_nt ? TOR : TOS;
        if (!d.reset && m_valid && m_me && d.escreveM) begin
            m_mem[m_addr]   = m_play;
            m_known[m_addr] = 1;
        end
        m_rd       = m_mem[m_addr];
        m_rd_known = m_known[m_addr];
        if (d.reset) begin
            m_valid = 1;
            m_addr = 0; m_round = 0; m_tm = 0; m_to = 0; m_play = 0;
            m_nj = 0; m_nt = 0; m_me = 0; m_prev = 1;
        end else if (m_valid) begin
            if (d.registraN) begin m_nj = d.nj; m_nt = d.nt; m_me = d.me; end
            if (d.registraR) m_play = int'(d.botoes);
            if (d.zeraC) m_addr = 0;
            else if (d.contaC) m_addr = (m_addr + 1) % PROF;
            if (d.zeraCR) m_round = 0;
            else if (d.contaCR && m_round < PROF - 1) m_round = m_round + 1;
            if (d.zeraTM) m_tm = 0;
            else if (d.contaTM) m_tm = (m_tm + 1) % TMS;
            if (d.zeraTempo || jf) m_to = 0;
            else if (d.contaTempo) m_to = (m_to + 1 >= to_m) ? 0 : m_to + 1;
            m_prev = (d.botoes != 0);
        end
    endtask

    task automatic apply(input drv_t d);
        reset             = d.reset;
        bus.botoes        = d.botoes;
        bus.nivel_jogadas = d.nj;
        bus.nivel_tempo   = d.nt;
        bus.modo_escrita  = d.me;
        bus.registraN     = d.registraN;
        bus.zeraC         = d.zeraC;
        bus.contaC        = d.contaC;
        bus.zeraCR        = d.zeraCR;
        bus.contaCR       = d.contaCR;
        bus.registraR     = d.registraR;
        bus.escreveM      = d.escreveM;
        bus.zeraTM        = d.zeraTM;
        bus.contaTM       = d.contaTM;
        bus.zeraTempo     = d.zeraTempo;
        bus.contaTempo    = d.contaTempo;
        bus.ativa_leds    = d.ativa;
    endtask

    // One clock cycle: drive, predict, advance the model at the edge
    task automatic cyc(input drv_t d);
        apply(d);
        if (m_valid) exp_q.push_back(predict(d));
        @(posedge clock);
        model_step(d);
        #1;
    endtask

    task automatic set_modes(input bit nj, input bit nt, input bit me);
        drv_t d = '0;
        d.registraN = 1; d.nj = nj; d.nt = nt; d.me = me;
        cyc(d);
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, act, expv);
        end
    endtask

    // Monitor: compare the DUT against the oldest prediction each cycle
    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("jogada_feita",   int'(bus.jogada_feita),        int'(e.jf));
            chk("jogada_valida",  int'(bus.jogada_valida),       int'(e.jv));
            if (e.jc_known) chk("jogada_correta", int'(bus.jogada_correta), int'(e.jc));
            chk("nivel_jogadas_reg", int'(bus.nivel_jogadas_reg), int'(e.nj));
            chk("nivel_tempo_reg",   int'(bus.nivel_tempo_reg),   int'(e.nt));
            chk("modo_escrita_reg",  int'(bus.modo_escrita_reg),  int'(e.me));
            chk("fimC",          int'(bus.fimC),                int'(e.fimC));
            chk("enderecoIgual", int'(bus.enderecoIgualRodada), int'(e.eir));
            chk("fimCR",         int'(bus.fimCR),               int'(e.fimCR));
            chk("fimTM",         int'(bus.fimTM),               int'(e.fimTM));
            chk("meioTM",        int'(bus.meioTM),              int'(e.meioTM));
            chk("fimTempo",      int'(bus.fimTempo),            int'(e.fimTo));
            chk("meioTempo",     int'(bus.meioTempo),           int'(e.meioTo));
            if (e.leds_known) chk("leds", int'(bus.leds), e.leds);
            chk("db_endereco",   int'(bus.db_endereco),         e.endr);
            chk("db_rodada",     int'(bus.db_rodada),           e.rod);
            chk("db_jogada",     int'(bus.db_jogada),           e.jog);
            if (e.mem_known) chk("db_memoria", int'(bus.db_memoria), e.memw);
        end
    end

    initial begin
        drv_t d;
        logic [NB-1:0] seq [3];
        seq[0] = 4'b0001; seq[1] = 4'b0100; seq[2] = 4'b1000;

        // Reset with a button held: no pulse until release and re-press
        d = '0; d.reset = 1; d.botoes = 4'b0010;
        repeat (2) cyc(d);
        d.reset = 0;
        repeat (3) cyc(d);
        d.botoes = '0;
        repeat (2) cyc(d);
        d.botoes = 4'b0010;
        repeat (3) cyc(d);
        d.botoes = '0;
        cyc(d);

        // Write mode: build the whole sequence, first three moves fixed
        set_modes(0, 0, 1);
        for (int i = 0; i < PROF; i++) begin
            d = '0; d.registraR = 1;
            d.botoes = (i < 3) ? seq[i] : NB'(1 << $urandom_range(0, NB - 1));
            cyc(d);
            d = '0; d.escreveM = 1; cyc(d);
            d = '0; d.contaC = 1;   cyc(d);
        end
        d = '0; d.zeraC = 1; cyc(d);
        d = '0; d.ativa = 1; repeat (2) cyc(d);
        d.contaC = 1; repeat (4) cyc(d);

        // escreveM ignored outside write mode
        set_modes(0, 0, 0);
        d = '0; d.zeraC = 1; d.registraR = 1; d.botoes = 4'b1111; cyc(d);
        d = '0; d.escreveM = 1; d.ativa = 1; repeat (3) cyc(d);

        // Play compare against memory[0] = 0100
        set_modes(0, 0, 1);
        d = '0; d.zeraC = 1; d.registraR = 1; d.botoes = 4'b0100; cyc(d);
        d = '0; d.escreveM = 1; cyc(d);
        set_modes(0, 0, 0);
        d = '0; d.ativa = 1; repeat (2) cyc(d);
        d.registraR = 1; d.botoes = 4'b0100; cyc(d);
        d.registraR = 0; d.botoes = '0; repeat (2) cyc(d);
        d.registraR = 1; d.botoes = 4'b0110; cyc(d);
        d.registraR = 0; d.botoes = '0; repeat (2) cyc(d);
        d.registraR = 1; d.botoes = 4'b0000; cyc(d);
        d.registraR = 0; repeat (2) cyc(d);

        // Round limit for both levels, with saturation
        set_modes(0, 0, 0);
        d = '0; d.zeraCR = 1; cyc(d);
        d = '0; d.contaCR = 1; repeat (20) cyc(d);
        set_modes(1, 0, 0);
        d = '0; repeat (2) cyc(d);
        d = '0; d.zeraCR = 1; cyc(d);
        d = '0; d.contaCR = 1; repeat (20) cyc(d);
        d = '0; d.zeraC = 1; d.zeraCR = 1; cyc(d);
        d = '0; d.contaC = 1; d.contaCR = 1; repeat (3) cyc(d);
        d = '0; d.contaC = 1; repeat (2) cyc(d);

        // Display timer across a full period
        d = '0; d.zeraTM = 1; cyc(d);
        d = '0; d.contaTM = 1; repeat (TMS + 2) cyc(d);

        // Fast timeout, then a play restarting it mid-window
        set_modes(1, 1, 0);
        d = '0; d.zeraTempo = 1; cyc(d);
        d = '0; d.contaTempo = 1; repeat (TOR + 3) cyc(d);
        d = '0; d.zeraTempo = 1; cyc(d);
        d = '0; d.contaTempo = 1; repeat (5000) cyc(d);
        d.botoes = 4'b0001; cyc(d);
        d.botoes = '0; repeat (TOR / 2 + 10) cyc(d);

        // Level change while beyond the new modulus wraps on next enable
        set_modes(1, 0, 0);
        d = '0; d.zeraTempo = 1; cyc(d);
        d = '0; d.contaTempo = 1; repeat (10000) cyc(d);
        set_modes(1, 1, 0);
        d = '0; d.contaTempo = 1; repeat (TOR / 2 + 2) cyc(d);

        // Address wrap and clear priority
        d = '0; d.zeraC = 1; cyc(d);
        d = '0; d.contaC = 1; repeat (PROF + 1) cyc(d);
        d = '0; d.zeraC = 1; d.contaC = 1; repeat (2) cyc(d);

        // Randomised operation
        for (int n = 0; n < 3000; n++) begin
            d = '0;
            d.reset      = ($urandom_range(0, 127) == 0);
            d.botoes     = ($urandom_range(0, 1) == 0) ? '0 : NB'($urandom);
            d.nj         = 1'($urandom);
            d.nt         = 1'($urandom);
            d.me         = 1'($urandom);
            d.registraN  = ($urandom_range(0, 7) == 0);
            d.zeraC      = ($urandom_range(0, 15) == 0);
            d.contaC     = 1'($urandom);
            d.zeraCR     = ($urandom_range(0, 15) == 0);
            d.contaCR    = 1'($urandom);
            d.registraR  = 1'($urandom);
            d.escreveM   = 1'($urandom);
            d.zeraTM     = ($urandom_range(0, 31) == 0);
            d.contaTM    = 1'($urandom);
            d.zeraTempo  = ($urandom_range(0, 31) == 0);
            d.contaTempo = 1'($urandom);
            d.ativa      = 1'($urandom);
            cyc(d);
        end

        d = '0;
        repeat (2) cyc(d);
        @(negedge clock);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got=%0d expected=0 pending entries", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
